bus_owner_ctrl: RTL and testbench

Bus ownership controller sitting directly downstream of the 4-master configurable arbiter. It consumes the arbiter's registered one-hot grant, latches the winning master's transfer request, and drives a single shared slave port. It runs one request/ready handshake per ownership with a bounded wait, then returns an ack or error pulse plus read data to the owning master. One transfer per grant; no bursts.

---
 rtl/bus_pkg.sv | 39 +++
 rtl/bus_owner_ctrl_wait_timer.sv | 46 ++++
 rtl/bus_owner_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bus_owner_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus ownership path (arbiter, owner controller
// and their benches).
//   NUM_MASTERS   : number of requesting masters
//   IDX_W         : width of a master index
//   bus_state_e   : owner-controller FSM encoding (IDLE / REQ / DONE)
//   is_onehot     : true when exactly one bit of a grant vector is set
//   onehot_to_idx : index of the set bit of a one-hot grant vector
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int IDX_W       = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

    function automatic logic is_onehot(input logic [NUM_MASTERS-1:0] v);
        return (v != '0) && ((v & (v - NUM_MASTERS'(1))) == '0);
    endfunction

    // Only meaningful when is_onehot(v) holds; multi-hot inputs give an OR
    // of the indices, which callers must reject beforehand.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (v[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_owner_ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts wait cycles of a slave request and flags when the allowed budget is
// used up.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to zero (has priority over enable)
//   enable     : advance the count by one
//   expired    : count has reached TIMEOUT-1; the count then holds
// -----------------------------------------------------------------------------
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    // Holding at the expiry value keeps the counter from ever wrapping even
    // if enable were left high.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_owner_ctrl.sv
// -----------------------------------------------------------------------------
// bus_owner_ctrl
// Takes the arbiter's one-hot grant, latches the winning master's request and
// runs a single transfer on the shared slave port, then returns an ack or a
// timeout error pulse to that master.
//   clk, rst_n            : clock, asynchronous active-low reset
//   gnt                   : one-hot grant from the arbiter
//   m_valid/m_we          : per-master request pending / write enable
//   m_addr/m_wdata        : per-master address / write data, master i at [i*W +: W]
//   m_ack/m_err           : one-cycle completion / timeout pulse to the owner
//   m_rdata               : read data, valid with m_ack
//   s_valid/s_we/s_addr/s_wdata : slave request
//   s_ready/s_rdata       : slave completion and read data
//   busy                  : controller is not idle
//   owner                 : index of the current or last owner
//
// Slave handshake: s_valid rises after the grant is accepted and stays high,
// with s_we/s_addr/s_wdata stable, until the first edge that samples s_ready
// high (transfer complete, read data taken that same edge) or until TIMEOUT
// request cycles have passed without s_ready. s_ready outside a request is
// ignored. A ready on the final allowed cycle counts as completion.
// -----------------------------------------------------------------------------
module bus_owner_ctrl
    import bus_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS-1:0]    gnt,
    input  logic [NUM_MASTERS-1:0]    m_valid,
    input  logic [NUM_MASTERS-1:0]    m_we,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [DW-1:0]             m_rdata,
    output logic                      s_valid,
    output logic                      s_we,
    output logic [AW-1:0]             s_addr,
    output logic [DW-1:0]             s_wdata,
    input  logic                      s_ready,
    input  logic [DW-1:0]             s_rdata,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
);

    bus_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             ok_q, ok_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expired;

    logic             gnt_ok;
    logic [IDX_W-1:0] gnt_idx;
    logic [NUM_MASTERS-1:0] owner_onehot;

    assign gnt_ok  = is_onehot(gnt);
    assign gnt_idx = onehot_to_idx(gnt);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ok_d    = ok_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Master inputs are only looked at here; afterwards the
                // latched copy drives the slave so upstream changes are harmless.
                if (gnt_ok && m_valid[gnt_idx]) begin
                    owner_d = gnt_idx;
                    we_d    = m_we[gnt_idx];
                    addr_d  = m_addr[gnt_idx*AW +: AW];
                    wdata_d = m_wdata[gnt_idx*DW +: DW];
                    tmr_clr = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ready is checked before expiry so a last-cycle ready wins.
                if (s_ready) begin
                    if (!we_q) begin
                        rdata_d = s_rdata;
                    end
                    ok_d    = 1'b1;
                    state_d = ST_DONE;
                end else if (tmr_expired) begin
                    ok_d    = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ok_q    <= ok_d;
        end
    end

    // Every output comes from registers, so s_ready never reaches a master
    // output combinationally.
    assign owner_onehot = NUM_MASTERS'(1) << owner_q;

    assign s_valid = (state_q == ST_REQ);
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;

    assign m_ack   = (state_q == ST_DONE &&  ok_q) ? owner_onehot : '0;
    assign m_err   = (state_q == ST_DONE && !ok_q) ? owner_onehot : '0;
    assign m_rdata = rdata_q;

    assign busy    = (state_q != ST_IDLE);
    assign owner   = owner_q;

endmodule

// File: tb/tb_bus_owner_ctrl.sv
module tb_bus_owner_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int TIMEOUT = 15;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    gnt = '0;
  logic [3:0]    m_valid = '0;
  logic [3:0]    m_we = '0;
  logic [4*AW-1:0] m_addr = '0;
  logic [4*DW-1:0] m_wdata = '0;
  logic [3:0]    m_ack;
  logic [3:0]    m_err;
  logic [DW-1:0] m_rdata;
  logic          s_valid;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ready = 1'b0;
  logic [DW-1:0] s_rdata = '0;
  logic          busy;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  bus_owner_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt     (gnt),
    .m_valid (m_valid),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .s_valid (s_valid),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ready (s_ready),
    .s_rdata (s_rdata),
    .busy    (busy),
    .owner   (owner)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  // {owner[1:0], ack[3:0], err[3:0], rdata[7:0]}
  logic [17:0] exp_q[$];
  logic [7:0]  model_rdata = '0;
  logic [1:0]  model_owner = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy,    0);
    check({tag, "_valid"}, s_valid, 0);
    check({tag, "_ack"},   m_ack,   0);
    check({tag, "_err"},   m_err,   0);
  endtask

  task automatic check_reset_values(input string tag);
    check_idle_outputs(tag);
    check({tag, "_swe"},   s_we,    0);
    check({tag, "_saddr"}, s_addr,  0);
    check({tag, "_swdat"}, s_wdata, 0);
    check({tag, "_rdata"}, m_rdata, 0);
    check({tag, "_owner"}, owner,   0);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_masters(input logic [3:0] g, input logic [3:0] v, input int tgt,
                               input logic we, input logic [7:0] a, input logic [7:0] d);
    gnt     = g;
    m_valid = v;
    m_we    = 4'($urandom);
    m_addr  = 32'($urandom);
    m_wdata = 32'($urandom);
    m_we[tgt] = we;
    m_addr[tgt*AW +: AW]  = a;
    m_wdata[tgt*DW +: DW] = d;
  endtask

  // Called on a falling edge. ready_at: REQ cycle (1-based) on which the
  // slave answers; 0 or anything past TIMEOUT means the slave never answers.
  // busy_gnt: grant shown while the transfer runs (0 = random noise).
  task automatic run_txn(input logic [3:0] g, input logic [3:0] v, input logic we,
                         input logic [7:0] a, input logic [7:0] d, input int ready_at,
                         input logic [7:0] rd, input logic [3:0] busy_gnt);
    int   k;
    bit   accept;
    bit   got_ack;
    int   exp_cycles;
    logic [7:0]  exp_rdata;
    logic [17:0] exp;
    int   n;
    bit   done;

    k = 0;
    for (int i = 3; i >= 0; i--) if (g[i]) k = i;
    drive_masters(g, v, k, we, a, d);
    s_ready = 1'b0;
    accept = ($countones(g) == 1) && v[k];

    if (!accept) begin
      @(negedge clk);
      check_idle_outputs("ignored");
      @(negedge clk);
      check_idle_outputs("ignored2");
      gnt = '0;
      m_valid = '0;
      return;
    end

    got_ack    = (ready_at >= 1) && (ready_at <= TIMEOUT);
    exp_cycles = got_ack ? ready_at : TIMEOUT;
    exp_rdata  = (got_ack && !we) ? rd : model_rdata;
    model_owner = 2'(k);
    exp_q.push_back({2'(k), got_ack ? 4'(1 << k) : 4'b0, got_ack ? 4'b0 : 4'(1 << k), exp_rdata});

    n = 0;
    done = 0;
    for (int c = 0; c < TIMEOUT + 3 && !done; c++) begin
      @(negedge clk);
      if (s_valid) begin
        n++;
        check("req_we",    s_we,    we);
        check("req_addr",  s_addr,  a);
        check("req_wdata", s_wdata, d);
        check("req_owner", owner,   model_owner);
        check("req_busy",  busy,    1);
        check("req_noack", m_ack | m_err, 0);
        drive_masters(busy_gnt != 0 ? busy_gnt : 4'($urandom), 4'($urandom),
                      $urandom_range(0, 3), 1'($urandom), 8'($urandom), 8'($urandom));
        s_ready = (n == ready_at);
        s_rdata = (n == ready_at) ? rd : 8'($urandom);
      end else begin
        done = 1;
      end
    end

    // Now in the response cycle; stop offering grants before IDLE samples.
    s_ready = 1'b0;
    gnt     = '0;
    m_valid = '0;
    check("valid_cycles", n, exp_cycles);
    exp = exp_q.pop_front();
    check("rsp_owner", owner,   exp[17:16]);
    check("rsp_ack",   m_ack,   exp[15:12]);
    check("rsp_err",   m_err,   exp[11:8]);
    check("rsp_rdata", m_rdata, exp[7:0]);
    check("rsp_busy",  busy,    1);
    model_rdata = exp_rdata;

    @(negedge clk);
    check_idle_outputs("after");
    check("after_rdata", m_rdata, model_rdata);
    check("after_owner", owner,   model_owner);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [3:0] g;
    logic [3:0] v;
    int         ra;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Write, slave ready immediately.
    run_txn(4'b0100, 4'b0100, 1'b1, 8'h3C, 8'hA5, 1, 8'h00, 4'b0);
    // Read with a wait: ready on the 4th request cycle.
    run_txn(4'b0001, 4'b0001, 1'b0, 8'h10, 8'h00, 4, 8'h5E, 4'b0);
    // Timeout: slave never answers, read data must stay at 0x5E.
    run_txn(4'b0010, 4'b0010, 1'b0, 8'h20, 8'h00, 0, 8'hFF, 4'b0);
    // Ready on the last allowed cycle: ack, not err.
    run_txn(4'b1000, 4'b1000, 1'b0, 8'h30, 8'h00, TIMEOUT, 8'hC3, 4'b0);
    // Invalid grants.
    run_txn(4'b0110, 4'b1111, 1'b1, 8'h40, 8'h41, 1, 8'h00, 4'b0);
    run_txn(4'b1000, 4'b0111, 1'b1, 8'h50, 8'h51, 1, 8'h00, 4'b0);
    run_txn(4'b0000, 4'b1111, 1'b1, 8'h60, 8'h61, 1, 8'h00, 4'b0);
    // Grant moves to master 3 while master 1 is being served.
    run_txn(4'b0010, 4'b1010, 1'b1, 8'h77, 8'h99, 3, 8'h00, 4'b1000);

    // Reset in the second request cycle.
    drive_masters(4'b0100, 4'b0100, 2, 1'b1, 8'h7A, 8'h7B);
    s_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_valid", s_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_rdata = '0;
    model_owner = '0;
    gnt = '0;
    m_valid = '0;
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("in_rst");
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
    run_txn(4'b0001, 4'b0001, 1'b0, 8'h81, 8'h00, 2, 8'h6D, 4'b0);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) != 0) g = 4'(1 << $urandom_range(0, 3));
      else g = 4'($urandom);
      v = 4'($urandom);
      if ($urandom_range(0, 4) != 0) v = v | g;
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, TIMEOUT + 2);
      else ra = $urandom_range(1, 4);
      run_txn(g, v, 1'($urandom), 8'($urandom), 8'($urandom), ra, 8'($urandom), 4'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
